seg7_scan_driver: RTL and testbench

- Output stage fed directly by the CPU top level: it consumes the 8-bit display register and the busy, inp_take and pc_disp status flags.
- Drives the 4-digit multiplexed 7-segment display (led, d1..d4) and the 8 discrete LEDs (s_led).
- Converts the binary value to 3 BCD digits with a sequential double-dabble engine.
- Scans one digit at a time and shows a mode glyph on the leftmost digit.

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 243 ++++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the CPU top level and the 7-segment / LED output stage.
// The CPU side drives value and mode flags; the display side drives the pins.
interface seg7_scan_driver_if;
  logic [7:0] inp;
  logic       busy;
  logic       inp_take;
  logic       pc_disp;
  logic [6:0] led;
  logic       d1;
  logic       d2;
  logic       d3;
  logic       d4;
  logic [7:0] s_led;

  modport master (
    output inp, busy, inp_take, pc_disp,
    input  led, d1, d2, d3, d4, s_led
  );

  modport slave (
    input  inp, busy, inp_take, pc_disp,
    output led, d1, d2, d3, d4, s_led
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver with a sequential binary-to-BCD converter,
// a mode glyph on the leftmost digit and a busy chaser on the discrete LEDs.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 32'd50000,
  parameter int unsigned CHASE_DIV = 32'd12500000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int CHASE_W = $clog2(CHASE_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 32'd1);
  localparam logic [CHASE_W-1:0] CHASE_LAST = CHASE_W'(CHASE_DIV - 32'd1);
  localparam logic [6:0] BLANK   = 7'h7F;
  localparam logic [6:0] GLYPH_P = 7'h0C;
  localparam logic [6:0] GLYPH_I = 7'h79;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_digit(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [11:0] dabble_adjust(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  conv_state_e  state_r;
  conv_state_e  state_nxt_s;
  logic         load_s;
  logic         shift_s;
  logic         commit_s;
  logic         commit_r;
  logic [7:0]   shift_r;
  logic [7:0]   shown_r;
  logic [11:0]  scratch_r;
  logic [11:0]  adj_s;
  logic [2:0]   bit_cnt_r;
  logic [3:0]   hund_r;
  logic [3:0]   tens_r;
  logic [3:0]   ones_r;

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic               scan_wrap_s;
  logic [1:0]         idx_r;
  logic [1:0]         idx_nxt_s;
  logic [6:0]         led_nxt_s;
  logic [3:0]         d_nxt_s;
  logic [6:0]         led_r;
  logic [3:0]         d_r;

  logic [CHASE_W-1:0] chase_cnt_r;
  logic [2:0]         chase_pos_r;
  logic               busy_d_r;
  logic [7:0]         s_led_r;

  // Converter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Converter next-state logic; IDLE holds off one cycle while the result is being published
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if ((bus.inp != shown_r) && !commit_r) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Converter control outputs
  always_comb begin
    load_s   = 1'b0;
    shift_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE:    load_s   = (bus.inp != shown_r) && !commit_r;
      SHIFT:   shift_s  = 1'b1;
      COMMIT:  commit_s = 1'b1;
      default: load_s   = 1'b0;
    endcase
  end

  // Add-3 correction applied to the scratch BCD before each shift
  always_comb begin
    adj_s = dabble_adjust(scratch_r);
  end

  // Converter datapath: capture, shift, and publish the finished digits
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_r  <= 1'b0;
      shift_r   <= 8'd0;
      shown_r   <= 8'd0;
      scratch_r <= 12'd0;
      bit_cnt_r <= 3'd0;
      hund_r    <= 4'd0;
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
    end else begin
      commit_r <= commit_s;
      if (load_s) begin
        shift_r   <= bus.inp;
        shown_r   <= bus.inp;
        scratch_r <= 12'd0;
        bit_cnt_r <= 3'd0;
      end else if (shift_s) begin
        scratch_r <= {adj_s[10:0], shift_r[7]};
        shift_r   <= {shift_r[6:0], 1'b0};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (commit_r) begin
        hund_r <= scratch_r[11:8];
        tens_r <= scratch_r[7:4];
        ones_r <= scratch_r[3:0];
      end
    end
  end

  // Scan index and the glyph for the digit that will be enabled next
  always_comb begin
    scan_wrap_s = (scan_cnt_r == SCAN_LAST);
    if (scan_wrap_s) begin
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      idx_nxt_s = idx_r;
    end
    d_nxt_s = ~(4'b0001 << idx_nxt_s);
    case (idx_nxt_s)
      2'd0: begin
        if (bus.pc_disp) begin
          led_nxt_s = GLYPH_P;
        end else if (bus.inp_take) begin
          led_nxt_s = GLYPH_I;
        end else begin
          led_nxt_s = BLANK;
        end
      end
      2'd1:    led_nxt_s = (hund_r == 4'd0) ? BLANK : seg_digit(hund_r);
      2'd2:    led_nxt_s = ((hund_r == 4'd0) && (tens_r == 4'd0)) ? BLANK : seg_digit(tens_r);
      2'd3:    led_nxt_s = seg_digit(ones_r);
      default: led_nxt_s = BLANK;
    endcase
  end

  // Scanner registers; segments and enables move together to avoid ghosting
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd0;
      led_r      <= BLANK;
      d_r        <= 4'hF;
    end else begin
      scan_cnt_r <= scan_wrap_s ? '0 : scan_cnt_r + SCAN_W'(1);
      idx_r      <= idx_nxt_s;
      led_r      <= led_nxt_s;
      d_r        <= d_nxt_s;
    end
  end

  // Discrete LEDs: shown value when idle, one-hot chaser while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      chase_cnt_r <= '0;
      chase_pos_r <= 3'd0;
      busy_d_r    <= 1'b0;
      s_led_r     <= 8'd0;
    end else begin
      busy_d_r <= bus.busy;
      if (bus.busy && !busy_d_r) begin
        chase_cnt_r <= '0;
        chase_pos_r <= 3'd0;
        s_led_r     <= 8'h01;
      end else if (bus.busy) begin
        if (chase_cnt_r == CHASE_LAST) begin
          chase_cnt_r <= '0;
          chase_pos_r <= chase_pos_r + 3'd1;
          s_led_r     <= 8'h01 << (chase_pos_r + 3'd1);
        end else begin
          chase_cnt_r <= chase_cnt_r + CHASE_W'(1);
          s_led_r     <= 8'h01 << chase_pos_r;
        end
      end else begin
        s_led_r <= shown_r;
      end
    end
  end

  assign bus.led   = led_r;
  assign bus.d1    = d_r[0];
  assign bus.d2    = d_r[1];
  assign bus.d3    = d_r[2];
  assign bus.d4    = d_r[3];
  assign bus.s_led = s_led_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (SCAN_DIV=4, CHASE_DIV=3): cycle model feeding a
// scoreboard queue, a table of per-digit glyph vectors, and hand-written corner sequences.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.SCAN_DIV(32'd4), .CHASE_DIV(32'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] inp;
    logic       pc_disp;
    logic       inp_take;
    logic [6:0] g1;
    logic [6:0] g2;
    logic [6:0] g3;
    logic [6:0] g4;
  } vec_t;

  vec_t        vecs[7];
  logic [18:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // reference model state
  int         m_shown, m_val, m_timer, m_h, m_t, m_o;
  int         m_cnt, m_idx, m_pos, m_ccnt;
  logic       m_busy_d;
  logic [6:0] m_led;
  logic [3:0] m_d;
  logic [7:0] m_sled;

  function automatic logic [6:0] glyph_of(input int v);
    case (v)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_shown = 0; m_val = 0; m_timer = 0; m_h = 0; m_t = 0; m_o = 0;
      m_cnt = 0; m_idx = 0; m_pos = 0; m_ccnt = 0; m_busy_d = 1'b0;
      m_led = 7'h7F; m_d = 4'hF; m_sled = 8'd0;
    end else begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
      case (m_idx)
        0:       m_led = bus.pc_disp ? 7'h0C : (bus.inp_take ? 7'h79 : 7'h7F);
        1:       m_led = (m_h == 0) ? 7'h7F : glyph_of(m_h);
        2:       m_led = (m_h == 0 && m_t == 0) ? 7'h7F : glyph_of(m_t);
        default: m_led = glyph_of(m_o);
      endcase
      m_d = 4'hF;
      m_d[m_idx] = 1'b0;
      if (bus.busy && !m_busy_d) begin
        m_pos = 0; m_ccnt = 0; m_sled = 8'h01;
      end else if (bus.busy) begin
        if (m_ccnt == 2) begin
          m_ccnt = 0;
          m_pos = (m_pos + 1) % 8;
        end else begin
          m_ccnt++;
        end
        m_sled = 8'd0;
        m_sled[m_pos] = 1'b1;
      end else begin
        m_sled = 8'(m_shown);
      end
      m_busy_d = bus.busy;
      if (m_timer == 10) begin
        m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
        m_timer = 0;
      end else if (m_timer > 0) begin
        m_timer++;
      end else if (int'(bus.inp) != m_shown) begin
        m_shown = int'(bus.inp); m_val = int'(bus.inp); m_timer = 1;
      end
    end
  endtask

  task automatic step(input int n);
    logic [18:0] e;
    logic [18:0] a;
    for (int k = 0; k < n; k++) begin
      model_edge();
      exp_q.push_back({m_led, m_d, m_sled});
      @(posedge clk);
      #1;
      a = {bus.led, bus.d4, bus.d3, bus.d2, bus.d1, bus.s_led};
      e = exp_q.pop_front();
      check("cycle_model", 32'(a), 32'(e));
    end
  endtask

  initial begin
    vecs[0] = '{8'd0,   1'b0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[1] = '{8'd255, 1'b0, 1'b0, 7'h7F, 7'h24, 7'h12, 7'h12};
    vecs[2] = '{8'd7,   1'b0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h78};
    vecs[3] = '{8'd105, 1'b1, 1'b1, 7'h0C, 7'h79, 7'h40, 7'h12};
    vecs[4] = '{8'd105, 1'b0, 1'b1, 7'h79, 7'h79, 7'h40, 7'h12};
    vecs[5] = '{8'd38,  1'b0, 1'b0, 7'h7F, 7'h7F, 7'h30, 7'h00};
    vecs[6] = '{8'd190, 1'b1, 1'b0, 7'h0C, 7'h79, 7'h10, 7'h40};

    rst = 1'b1;
    bus.inp = 8'd0; bus.busy = 1'b0; bus.inp_take = 1'b0; bus.pc_disp = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);

    // reset in the middle of a conversion
    bus.inp = 8'd200;
    step(4);
    rst = 1'b1;
    step(1);
    check("reset_led", 32'(bus.led), 32'h7F);
    check("reset_digits", 32'({bus.d4, bus.d3, bus.d2, bus.d1}), 32'hF);
    check("reset_s_led", 32'(bus.s_led), 32'h00);
    rst = 1'b0;
    bus.inp = 8'd0;

    // per-digit glyph table
    for (int v = 0; v < 7; v++) begin
      bus.inp = vecs[v].inp;
      bus.pc_disp = vecs[v].pc_disp;
      bus.inp_take = vecs[v].inp_take;
      step(14);
      for (int c = 0; c < 16; c++) begin
        step(1);
        if (m_d[0] == 1'b0) check("glyph_d1", 32'(bus.led), 32'(vecs[v].g1));
        else if (m_d[1] == 1'b0) check("glyph_d2", 32'(bus.led), 32'(vecs[v].g2));
        else if (m_d[2] == 1'b0) check("glyph_d3", 32'(bus.led), 32'(vecs[v].g3));
        else check("glyph_d4", 32'(bus.led), 32'(vecs[v].g4));
      end
    end
    bus.pc_disp = 1'b0;
    bus.inp_take = 1'b0;

    // 10-cycle conversion latency exercised at varying scan phases
    for (int k = 0; k < 8; k++) begin
      bus.inp = (k % 2 == 0) ? 8'd255 : 8'd0;
      step(12 + k);
    end

    // digit enables: one at a time, four cycles each
    begin
      int low_cnt[4];
      for (int i = 0; i < 4; i++) low_cnt[i] = 0;
      for (int c = 0; c < 16; c++) begin
        step(1);
        check("one_enable", 32'(int'(!bus.d1) + int'(!bus.d2) + int'(!bus.d3) + int'(!bus.d4)), 32'd1);
        if (!bus.d1) low_cnt[0]++;
        if (!bus.d2) low_cnt[1]++;
        if (!bus.d3) low_cnt[2]++;
        if (!bus.d4) low_cnt[3]++;
      end
      for (int i = 0; i < 4; i++) check("enable_dwell", 32'(low_cnt[i]), 32'd4);
    end

    // inp change during SHIFT: old sample finishes, then re-conversion
    bus.inp = 8'd10;
    step(4);
    bus.inp = 8'd20;
    step(30);

    // busy chaser, wrap, and return to shown value
    bus.busy = 1'b1;
    step(1);
    check("chase_start", 32'(bus.s_led), 32'h01);
    step(30);
    bus.busy = 1'b0;
    step(1);
    check("busy_release", 32'(bus.s_led), 32'd20);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
